// File: rtl/fp_operand_aligner_if.sv
`default_nettype none
// ============================================================================
// Module  : fp_operand_aligner_if
// Purpose : Operand/result handshake bundle for the FP adder alignment stage.
// Revision: 1.0 - initial release
// ============================================================================
interface fp_operand_aligner_if;
  logic        in__valid;
  logic        in__ready;
  logic [31:0] op__a;
  logic [31:0] op__b;
  logic        out__valid;
  logic        out__ready;
  logic [27:0] A;
  logic [27:0] B;
  logic [7:0]  exponent;
  logic        special;

  modport master (
    output in__valid, op__a, op__b, out__ready,
    input  in__ready, out__valid, A, B, exponent, special
  );

  modport slave (
    input  in__valid, op__a, op__b, out__ready,
    output in__ready, out__valid, A, B, exponent, special
  );
endinterface
`default_nettype wire

// File: rtl/fp_operand_aligner.sv
`default_nettype none
// ============================================================================
// Module  : fp_operand_aligner
// Purpose : Unpacks two binary32 operands and right-aligns the smaller one,
//           one bit per cycle with sticky collection, for the normalize stage.
// Revision: 1.0 - initial release
// ============================================================================
module fp_operand_aligner (
  input  wire logic           clk,
  input  wire logic           rst,
  fp_operand_aligner_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] c_exp_max   = 8'hFF;
  localparam logic [4:0] c_shift_sat = 5'd27;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_sign_a;
  logic        r_sign_b;
  logic [26:0] r_mag_a;
  logic [26:0] r_mag_b;
  logic [7:0]  r_exp;
  logic        r_special;
  logic [4:0]  r_count;
  logic        r_shift_b;

  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic [7:0]  w_e_a;
  logic [7:0]  w_e_b;
  logic [26:0] w_mag_a;
  logic [26:0] w_mag_b;
  logic        w_special;
  logic        w_a_big;
  logic [7:0]  w_diff;
  logic [4:0]  w_count;
  logic [7:0]  w_exp_big;
  logic        w_accept;

  function automatic logic [26:0] f_sticky_shift(input logic [26:0] m);
    return {1'b0, m[26:2], m[1] | m[0]};
  endfunction

  // Unpack: denormals get effective exponent 1 and no hidden bit.
  assign w_exp_a   = bus.op__a[30:23];
  assign w_exp_b   = bus.op__b[30:23];
  assign w_e_a     = (w_exp_a == 8'd0) ? 8'd1 : w_exp_a;
  assign w_e_b     = (w_exp_b == 8'd0) ? 8'd1 : w_exp_b;
  assign w_mag_a   = {(w_exp_a != 8'd0), bus.op__a[22:0], 3'b000};
  assign w_mag_b   = {(w_exp_b != 8'd0), bus.op__b[22:0], 3'b000};
  assign w_special = (w_exp_a == c_exp_max) || (w_exp_b == c_exp_max);
  assign w_a_big   = (w_e_a >= w_e_b);
  assign w_diff    = w_a_big ? (w_e_a - w_e_b) : (w_e_b - w_e_a);
  assign w_count   = w_special ? 5'd0 :
                     ((w_diff > 8'd27) ? c_shift_sat : w_diff[4:0]);
  assign w_exp_big = w_special ? c_exp_max : (w_a_big ? w_e_a : w_e_b);
  assign w_accept  = (r_state == S_IDLE) && bus.in__valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    bus.in__ready  = 1'b0;
    bus.out__valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in__ready = 1'b1;
        if (bus.in__valid) begin
          w_next_state = (w_count == 5'd0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_count == 5'd1) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        bus.out__valid = 1'b1;
        if (bus.out__ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Only the smaller-exponent magnitude moves; A/B never swap position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_mag_a   <= 27'd0;
      r_mag_b   <= 27'd0;
      r_exp     <= 8'd0;
      r_special <= 1'b0;
      r_count   <= 5'd0;
      r_shift_b <= 1'b0;
    end else if (w_accept) begin
      r_sign_a  <= bus.op__a[31];
      r_sign_b  <= bus.op__b[31];
      r_mag_a   <= w_mag_a;
      r_mag_b   <= w_mag_b;
      r_exp     <= w_exp_big;
      r_special <= w_special;
      r_count   <= w_count;
      r_shift_b <= w_a_big;
    end else if (r_state == S_SHIFT) begin
      if (r_shift_b) begin
        r_mag_b <= f_sticky_shift(r_mag_b);
      end else begin
        r_mag_a <= f_sticky_shift(r_mag_a);
      end
      r_count <= r_count - 5'd1;
    end
  end

  assign bus.A        = {r_sign_a, r_mag_a};
  assign bus.B        = {r_sign_b, r_mag_b};
  assign bus.exponent = r_exp;
  assign bus.special  = r_special;

endmodule
`default_nettype wire

// File: doc/fp_operand_aligner.md
# fp_operand_aligner

Multi-cycle alignment stage of the single-precision floating-point adder, directly upstream of the leading-one/normalize stage. It accepts two IEEE-754 binary32 operands through a valid/ready handshake and unpacks them. It then right-shifts the smaller-exponent mantissa one bit per cycle, collecting a sticky bit. It presents two 28-bit sign-magnitude mantissas plus the larger exponent, which is exactly the format the normalize stage consumes.

## Interface

- No parameters; all widths are fixed by binary32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- in__valid  in  1  operand pair valid.
- in__ready  out  1  block can accept; high only in IDLE.
- op__a  in  32  binary32 operand A.
- op__b  in  32  binary32 operand B.
- out__valid  out  1  aligned result valid.
- out__ready  in  1  downstream accepts result.
- A  out  28  {sign, 27-bit magnitude} of op__a after alignment.
- B  out  28  {sign, 27-bit magnitude} of op__b after alignment.
- exponent  out  8  common (larger effective) exponent.
- special  out  1  an operand had exponent 255; no alignment performed.

## Operation

- 27-bit magnitude layout: bit26 = hidden, bits25:3 = fraction, bit2 = guard, bit1 = round, bit0 = sticky.
- Unpack per operand:
  - hidden = (exp != 0);
  - effective exponent e = (exp == 0) ? 1 : exp;
  - magnitude = {hidden, frac, 3'b000}.
- Larger e selects the unshifted operand. On equal e, neither is shifted. A/B always keep op__a/op__b positions; there is no output swap.
- diff = e_big − e_small, an unsigned 8-bit value. Shift count = min(diff, 27).
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in__ready = 1. On in__valid && in__ready, capture operands and load the counter. Go to DONE if the count is 0 or special is set; otherwise go to SHIFT.
  - SHIFT: each cycle the small magnitude is updated to {0, mag[26:2], mag[1] | mag[0]}, and the counter decrements. When the counter reaches 1 (the final shift), go to DONE.
  - DONE: out__valid = 1 and all outputs are held stable. On out__valid && out__ready, go to IDLE.
- special: set if either exp == 255. In that case there is no shift, A/B carry the unshifted unpacked magnitudes, and exponent = 255.
- A negative zero magnitude is passed as sign = 1, magnitude 0. No canonicalization is done.
- Inputs are ignored outside IDLE. No new operand pair is accepted in the cycle a result is consumed.

## Timing

- Reset values: state IDLE, in__ready 1, out__valid 0, A 0, B 0, exponent 0, special 0, counter 0.
- Accept edge = E0. out__valid is high after edge E0 + min(diff, 27):
  - diff 0 or special: valid in the cycle after E0;
  - diff 3: valid after E3.
- Throughput is one result per min(diff, 27) + 2 cycles when out__ready is held high.
- out__ready low in DONE: every output is held bit-stable, in__ready stays 0, and there is no timeout.
- Shift saturation: for diff ≥ 27 the result magnitude is 0 with sticky = OR of all original bits.
- rst asserted in any state (including mid-SHIFT or DONE stalled):
  - immediately returns to reset values;
  - the in-flight operation is discarded;
  - no out__valid is produced for it after rst deasserts.
- rst deassertion with in__valid already high: the first accept happens on the first rising edge after deassertion.

## Test plan

- 1.0 + 1.0 (0x3F800000, 0x3F800000) -> out__valid one cycle after accept; A = B = 28'h4000000; exponent = 127; special = 0.
- 1.0 + 0.25 (0x3F800000, 0x3E800000), diff 2 -> valid after E2; A = 28'h4000000, B = 28'h1000000, exponent = 127.
- −1.5 + 2^-30 (0xBFC00000, 0x30800000), diff 30 clamped to 27 -> valid after E27; A = 28'hE000000, B = 28'h0000001 (sticky only), exponent = 127.
- Denormal vs min-normal (0x00000001, 0x00800000) -> diff 0; A = 28'h0000008, B = 28'h4000000, exponent = 1. Separately, (0x7F800000, 0x3F800000) -> special = 1, exponent = 255, latency 1.
- Backpressure: result in DONE, out__ready low for 5 cycles while in__valid toggles with new operands -> outputs unchanged, in__ready = 0, no accept. Raise out__ready -> IDLE next cycle, then the new pair is accepted.
- Reset mid-SHIFT: assert rst at E10 of a diff-20 operation -> out__valid = 0, in__ready = 1 immediately. After release, a 1.0 + 1.0 operation completes correctly with no stale result.
